// File: rtl/bus_op_responder_if.sv
// Bus-side signal bundle between the LLC bus master and the shared-bus responder.
// The master drives requests, snoop inputs, writeback completion and response acceptance.
interface bus_op_responder_if #(
  parameter int ADDR_BITS = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 snp_hit;
  logic                 snp_hitm;
  logic                 wb_done;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_snoop;
  logic [ADDR_BITS-1:0] rsp_addr;
  logic                 rsp_err;

  modport master (
    output req_valid, req_op, req_addr, snp_hit, snp_hitm, wb_done, rsp_ready,
    input  req_ready, rsp_valid, rsp_snoop, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, snp_hit, snp_hitm, wb_done, rsp_ready,
    output req_ready, rsp_valid, rsp_snoop, rsp_addr, rsp_err
  );
endinterface

// File: rtl/bus_op_responder.sv
// Shared-bus responder: one operation at a time, snoop window, owner writeback wait,
// memory latency, response handshake and saturating per-operation statistics.
module bus_op_responder #(
  parameter int ADDR_BITS  = 32,
  parameter int SNOOP_LAT  = 2,
  parameter int MEM_LAT    = 4,
  parameter int WB_TIMEOUT = 16,
  parameter int CNT_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  bus_op_responder_if.slave   bus,
  output logic [CNT_BITS-1:0] cnt_reads,
  output logic [CNT_BITS-1:0] cnt_writes,
  output logic [CNT_BITS-1:0] cnt_inval,
  output logic [CNT_BITS-1:0] cnt_rwim,
  output logic [CNT_BITS-1:0] cnt_hitm
);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] SNP_HIT   = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b01;
  localparam logic [1:0] SNP_NOHIT = 2'b10;

  localparam int T_MAX0 = (SNOOP_LAT > MEM_LAT) ? SNOOP_LAT : MEM_LAT;
  localparam int T_MAX  = (T_MAX0 > WB_TIMEOUT) ? T_MAX0 : WB_TIMEOUT;
  localparam int TW     = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] T_SNOOP = TW'(SNOOP_LAT - 1);
  localparam logic [TW-1:0] T_MEM   = TW'(MEM_LAT - 1);
  localparam logic [TW-1:0] T_WB    = TW'(WB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SNOOP   = 3'd1,
    S_WB_WAIT = 3'd2,
    S_MEM     = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [TW-1:0]        r_timer;
  logic [2:0]           r_op;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_hit_acc;
  logic                 r_hitm_acc;
  logic [1:0]           r_snoop;
  logic                 r_err;

  logic       w_hit_now;
  logic       w_hitm_now;
  logic [1:0] w_snoop_res;
  logic       w_legal_in;
  logic       w_legal_op;
  logic       w_rsp_hs;
  logic [4:0] w_cnt_inc;

  // The current cycle's snoop inputs join the accumulators so the last window cycle counts.
  assign w_hit_now   = r_hit_acc | bus.snp_hit;
  assign w_hitm_now  = r_hitm_acc | bus.snp_hitm;
  assign w_snoop_res = w_hitm_now ? SNP_HITM : (w_hit_now ? SNP_HIT : SNP_NOHIT);
  assign w_legal_in  = (bus.req_op >= OP_READ) && (bus.req_op <= OP_RWIM);
  assign w_legal_op  = (r_op >= OP_READ) && (r_op <= OP_RWIM);
  assign w_rsp_hs    = (r_state == S_RESP) && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_WRITE) w_state_next = S_MEM;
          else if (w_legal_in)        w_state_next = S_SNOOP;
          else                        w_state_next = S_RESP;
        end
      end
      S_SNOOP: begin
        if (r_timer == '0) begin
          if (r_op == OP_INVAL) w_state_next = S_RESP;
          else if (w_hitm_now)  w_state_next = S_WB_WAIT;
          else                  w_state_next = S_MEM;
        end
      end
      S_WB_WAIT: begin
        if (bus.wb_done)          w_state_next = S_MEM;
        else if (r_timer == '0)   w_state_next = S_RESP;
      end
      S_MEM: begin
        if (r_timer == '0) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
  end

  assign bus.rsp_snoop = r_snoop;
  assign bus.rsp_addr  = r_addr;
  assign bus.rsp_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer    <= '0;
      r_op       <= '0;
      r_addr     <= '0;
      r_hit_acc  <= 1'b0;
      r_hitm_acc <= 1'b0;
      r_snoop    <= SNP_NOHIT;
      r_err      <= 1'b0;
    end else begin
      // Each timed state loads its own length on entry, then counts down to zero.
      if (w_state_next != r_state) begin
        case (w_state_next)
          S_SNOOP:   r_timer <= T_SNOOP;
          S_WB_WAIT: r_timer <= T_WB;
          S_MEM:     r_timer <= T_MEM;
          default:   r_timer <= r_timer;
        endcase
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op       <= bus.req_op;
            r_addr     <= bus.req_addr;
            r_hit_acc  <= 1'b0;
            r_hitm_acc <= 1'b0;
            r_snoop    <= SNP_NOHIT;
            r_err      <= ~w_legal_in;
          end
        end
        S_SNOOP: begin
          r_hit_acc  <= w_hit_now;
          r_hitm_acc <= w_hitm_now;
          if (r_timer == '0) begin
            r_snoop <= w_snoop_res;
            r_err   <= (r_op == OP_INVAL) && w_hitm_now;
          end
        end
        S_WB_WAIT: begin
          if (w_state_next == S_RESP) r_err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_cnt_inc[0] = w_rsp_hs && (r_op == OP_READ);
  assign w_cnt_inc[1] = w_rsp_hs && (r_op == OP_WRITE);
  assign w_cnt_inc[2] = w_rsp_hs && (r_op == OP_INVAL);
  assign w_cnt_inc[3] = w_rsp_hs && (r_op == OP_RWIM);
  assign w_cnt_inc[4] = w_rsp_hs && w_legal_op && (r_snoop == SNP_HITM);

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_reads  = g_cnt[0].r_cnt;
  assign cnt_writes = g_cnt[1].r_cnt;
  assign cnt_inval  = g_cnt[2].r_cnt;
  assign cnt_rwim   = g_cnt[3].r_cnt;
  assign cnt_hitm   = g_cnt[4].r_cnt;

endmodule

// File: tb/tb_bus_op_responder.sv
// Randomized scoreboard bench for bus_op_responder: the driver predicts each response from
// the operation rules, a separate monitor compares responses, latency, handshakes and counters.
module tb_bus_op_responder;
  localparam int SL   = 2;
  localparam int ML   = 4;
  localparam int WT   = 16;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_op_responder_if #(.ADDR_BITS(32)) bus ();
  logic [CB-1:0] cnt_reads, cnt_writes, cnt_inval, cnt_rwim, cnt_hitm;

  bus_op_responder #(
    .ADDR_BITS(32), .SNOOP_LAT(SL), .MEM_LAT(ML), .WB_TIMEOUT(WT), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cnt_reads(cnt_reads), .cnt_writes(cnt_writes), .cnt_inval(cnt_inval),
    .cnt_rwim(cnt_rwim), .cnt_hitm(cnt_hitm)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  snoop;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcnt[5] = '{0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bump(input int i);
    if (mcnt[i] < CMAX) mcnt[i]++;
  endtask

  // Monitor: compares whenever the responder presents a response.
  initial begin
    bit   prev_v = 1'b0;
    bit   hs_pend = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v  = 1'b0;
        hs_pend = 1'b0;
        continue;
      end
      if (hs_pend) begin
        chk("cnt_reads", cnt_reads, mcnt[0]);
        chk("cnt_writes", cnt_writes, mcnt[1]);
        chk("cnt_inval", cnt_inval, mcnt[2]);
        chk("cnt_rwim", cnt_rwim, mcnt[3]);
        chk("cnt_hitm", cnt_hitm, mcnt[4]);
        hs_pend = 1'b0;
      end
      chk("req_ready", bus.req_ready, q.size() == 0);
      if (q.size() == 0) begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
      end else if (bus.rsp_valid) begin
        e = q[0];
        if (!prev_v) chk("latency", cyc + 1 - e.acc, e.lat);
        chk("rsp_snoop", bus.rsp_snoop, e.snoop);
        chk("rsp_addr", bus.rsp_addr, e.addr);
        chk("rsp_err", bus.rsp_err, e.err);
        if (bus.rsp_ready) begin
          void'(q.pop_front());
          if (e.op >= 3'd1 && e.op <= 3'd4) begin
            bump(int'(e.op) - 1);
            if (e.snoop == 2'b01) bump(4);
          end
          hs_pend = 1'b1;
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  // Issue one op and play the snoop/writeback/response side for it until the response handshake.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] hitp_in,
                       input logic [7:0] hitmp_in, input int wbd, input int rdy, input bit hold_hitm);
    exp_t        e;
    logic [7:0]  hitp, hitmp;
    int          g, k, vcnt;
    bit          done, any_hit, any_hitm;
    hitp     = hitp_in;
    hitmp    = hold_hitm ? 8'hFF : hitmp_in;
    any_hit  = 1'b0;
    any_hitm = 1'b0;
    for (int i = 0; i < SL; i++) begin
      any_hit  |= hitp[i];
      any_hitm |= hitmp[i];
    end
    e.op    = op;
    e.addr  = addr;
    e.err   = 1'b0;
    e.snoop = 2'b10;
    if (op == 3'd0 || op > 3'd4) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (op == 3'd2) begin
      e.lat = 1 + ML;
    end else begin
      e.snoop = any_hitm ? 2'b01 : (any_hit ? 2'b00 : 2'b10);
      if (op == 3'd3) begin
        e.err = any_hitm;
        e.lat = 1 + SL;
      end else if (any_hitm) begin
        if (wbd <= WT) begin
          e.lat = 1 + SL + wbd + ML;
        end else begin
          e.lat = 1 + SL + WT;
          e.err = 1'b1;
        end
      end else begin
        e.lat = 1 + SL + ML;
      end
    end

    @(negedge clk);
    g = 0;
    while (!bus.req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got 0 expected 1 after 100 cycles");
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    e.acc         = cyc + 1;
    @(posedge clk);
    q.push_back(e);

    vcnt = 0;
    done = 1'b0;
    k    = 1;
    while (!done && k < 400) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_op    = 3'($urandom);
      bus.snp_hit   = (k <= SL) ? hitp[k-1] : 1'($urandom);
      bus.snp_hitm  = hold_hitm ? 1'b1 : ((k <= SL) ? hitmp[k-1] : 1'($urandom));
      bus.wb_done   = (k == SL + wbd) ? 1'b1 : ((k <= SL) ? 1'($urandom) : 1'b0);
      if (bus.rsp_valid) begin
        vcnt++;
        bus.rsp_ready = (vcnt > rdy);
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no response expected one within 400 cycles");
    end
    $display("txn op=%0d addr=%08h snoop=%02b err=%0d lat=%0d", op, addr, e.snoop, e.err, e.lat);
  endtask

  initial begin
    logic [2:0] op;
    exp_t       e;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'd0;
    bus.snp_hit   = 1'b0;
    bus.snp_hitm  = 1'b0;
    bus.wb_done   = 1'b0;
    bus.rsp_ready = 1'b0;

    #12;
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_snoop", bus.rsp_snoop, 2'b10);
    chk("reset_rsp_addr", bus.rsp_addr, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_cnt_all", {cnt_reads, cnt_writes, cnt_inval, cnt_rwim, cnt_hitm}, 0);
    #10 rst = 1'b0;

    issue(3'd1, 32'h0000_1000, 8'h00, 8'h00, 1, 0, 1'b0);
    issue(3'd4, 32'h0000_0040, 8'h00, 8'h02, 3, 1, 1'b0);
    issue(3'd3, 32'h0000_2000, 8'h03, 8'h00, 1, 0, 1'b0);
    issue(3'd3, 32'h0000_3000, 8'h00, 8'h01, 1, 2, 1'b0);
    issue(3'd2, 32'hFFFF_FFC0, 8'h00, 8'h00, 1, 3, 1'b1);
    issue(3'd1, 32'h0000_5000, 8'h01, 8'h01, WT + 4, 0, 1'b0);
    issue(3'd0, 32'h0000_6000, 8'h00, 8'h00, 1, 1, 1'b0);
    issue(3'd7, 32'h0000_7000, 8'h00, 8'h00, 1, 0, 1'b0);
    issue(3'd1, 32'h0000_8000, 8'h00, 8'h01, WT, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] hp, hmp;
      hp  = 8'h00;
      hmp = 8'h00;
      for (int i = 0; i < SL; i++) begin
        hp[i]  = ($urandom_range(0, 3) == 0);
        hmp[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       op = 3'd0;
          1:       op = 3'd5;
          2:       op = 3'd6;
          default: op = 3'd7;
        endcase
      end else begin
        op = 3'($urandom_range(1, 4));
      end
      issue(op, $urandom, hp, hmp, $urandom_range(1, WT + 2), $urandom_range(0, 3), 1'b0);
    end

    // Reset while a READ sits in its memory phase: it must vanish without a response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_addr  = 32'h0000_ABC0;
    bus.snp_hit   = 1'b0;
    bus.snp_hitm  = 1'b0;
    e.op = 3'd1; e.addr = 32'h0000_ABC0; e.snoop = 2'b10; e.err = 1'b0;
    e.lat = 1 + SL + ML; e.acc = cyc + 1;
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (SL + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_req_ready", bus.req_ready, 1);
    chk("midop_rsp_valid", bus.rsp_valid, 0);
    chk("midop_rsp_err", bus.rsp_err, 0);
    chk("midop_cnt_all", {cnt_reads, cnt_writes, cnt_inval, cnt_rwim, cnt_hitm}, 0);
    q.delete();
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);

    issue(3'd1, 32'h0000_1000, 8'h00, 8'h00, 1, 0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "global timeout");
  end

endmodule
